// File: rtl/sync_filter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_filter_pkg : shared state encodings and event-type constants  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package sync_filter_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    QUAL_LOW  = 2'd3
  } state_t;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;
  localparam int   STAB_W   = 8;

endpackage : sync_filter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : up-counter that holds at all-ones; clr wins over inc |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/sync_event_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_event_filter : debounces a synchronised level, emits edge     |
// | strobes, a valid/ready edge event and a saturating edge count.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_event_filter
  import sync_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             data_in,
  input  logic             clear,
  output logic             level_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             event_valid,
  output logic             event_type,
  input  logic             event_ready,
  output logic [CNT_W-1:0] event_count,
  output logic             overrun
);

  localparam logic [STAB_W-1:0] C_STABLE = STAB_W'(STABLE_CYCLES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STAB_W-1:0] w_stab_nxt;
  logic [STAB_W-1:0] w_stab_inc;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;
  logic              r_evt_valid;
  logic              r_evt_type;
  logic              r_overrun;
  logic              w_accept;
  logic              w_dir;
  logic              w_handshake;
  logic              w_drop;

  assign w_stab_inc = r_stab_cnt + STAB_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE_LOW;
      r_stab_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_accept    = 1'b0;
    w_dir       = EVT_RISE;
    case (r_state)
      IDLE_LOW: begin
        if (data_in) begin
          w_state_nxt = QUAL_HIGH;
          w_stab_nxt  = STAB_W'(1);
        end
      end
      QUAL_HIGH: begin
        if (!data_in) begin
          w_state_nxt = IDLE_LOW;
          w_stab_nxt  = '0;
        end else if (w_stab_inc == C_STABLE) begin
          w_state_nxt = IDLE_HIGH;
          w_stab_nxt  = '0;
          w_accept    = 1'b1;
          w_dir       = EVT_RISE;
        end else begin
          w_stab_nxt  = w_stab_inc;
        end
      end
      IDLE_HIGH: begin
        if (!data_in) begin
          w_state_nxt = QUAL_LOW;
          w_stab_nxt  = STAB_W'(1);
        end
      end
      QUAL_LOW: begin
        if (data_in) begin
          w_state_nxt = IDLE_HIGH;
          w_stab_nxt  = '0;
        end else if (w_stab_inc == C_STABLE) begin
          w_state_nxt = IDLE_LOW;
          w_stab_nxt  = '0;
          w_accept    = 1'b1;
          w_dir       = EVT_FALL;
        end else begin
          w_stab_nxt  = w_stab_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_stab_nxt  = '0;
      end
    endcase
  end

  // A completing handshake frees the slot in the same cycle, so a new edge can load.
  assign w_handshake = r_evt_valid && event_ready;
  assign w_drop      = w_accept && r_evt_valid && !event_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_level     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_evt_valid <= 1'b0;
      r_evt_type  <= 1'b0;
    end else begin
      r_rise <= w_accept && (w_dir == EVT_RISE);
      r_fall <= w_accept && (w_dir == EVT_FALL);
      if (w_accept) begin
        r_level <= w_dir;
      end
      if (w_accept && (!r_evt_valid || event_ready)) begin
        r_evt_valid <= 1'b1;
        r_evt_type  <= w_dir;
      end else if (w_handshake) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_sat_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_accept),
    .clr     (clear),
    .count   (event_count)
  );

  assign level_filt  = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign event_valid = r_evt_valid;
  assign event_type  = r_evt_type;
  assign overrun     = r_overrun;

endmodule : sync_event_filter
`default_nettype wire

// File: tb/tb_sync_event_filter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sync_event_filter : random + directed bench against a run-length|
// | reference model. Revision: 1.0                                    |
// +--------------------------------------------------------------------+
module tb_sync_event_filter;

  localparam int S      = 4;
  localparam int CNT_W  = 16;
  localparam int CNT_W3 = 3;

  logic              clock;
  logic              reset_n;
  logic              data_in;
  logic              clear;
  logic              event_ready;
  logic              level_filt, rise_pulse, fall_pulse, event_valid, event_type, overrun;
  logic [CNT_W-1:0]  event_count;
  logic              level_filt3, rise_pulse3, fall_pulse3, event_valid3, event_type3, overrun3;
  logic [CNT_W3-1:0] event_count3;

  int n_checks = 0;
  int n_fail   = 0;

  sync_event_filter #(.STABLE_CYCLES(S), .CNT_W(CNT_W)) u_dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .clear(clear),
    .level_filt(level_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .event_valid(event_valid), .event_type(event_type), .event_ready(event_ready),
    .event_count(event_count), .overrun(overrun)
  );

  sync_event_filter #(.STABLE_CYCLES(S), .CNT_W(CNT_W3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .clear(clear),
    .level_filt(level_filt3), .rise_pulse(rise_pulse3), .fall_pulse(fall_pulse3),
    .event_valid(event_valid3), .event_type(event_type3), .event_ready(event_ready),
    .event_count(event_count3), .overrun(overrun3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: level flips once S consecutive samples disagree with it.
  logic m_level, m_rise, m_fall, m_valid, m_type, m_ovr;
  int   m_run, m_cnt, m_cnt3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    logic acc, drop;
    acc  = 1'b0;
    drop = 1'b0;
    if (!reset_n) begin
      m_level = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_type = 0; m_ovr = 0;
      m_run = 0; m_cnt = 0; m_cnt3 = 0;
    end else begin
      if (data_in != m_level) begin
        m_run++;
        if (m_run == S) begin
          acc     = 1'b1;
          m_level = data_in;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_rise = acc && m_level;
      m_fall = acc && !m_level;
      if (acc) begin
        if (!m_valid || event_ready) begin
          m_valid = 1'b1;
          m_type  = m_level;
        end else begin
          drop = 1'b1;
        end
      end else if (m_valid && event_ready) begin
        m_valid = 1'b0;
      end
      if (clear) begin
        m_ovr = 0; m_cnt = 0; m_cnt3 = 0;
      end else begin
        if (drop) m_ovr = 1'b1;
        if (acc && m_cnt  < (1 << CNT_W)  - 1) m_cnt++;
        if (acc && m_cnt3 < (1 << CNT_W3) - 1) m_cnt3++;
      end
    end
  endtask

  task automatic compare_all();
    check("level_filt",  {31'd0, level_filt},  {31'd0, m_level});
    check("rise_pulse",  {31'd0, rise_pulse},  {31'd0, m_rise});
    check("fall_pulse",  {31'd0, fall_pulse},  {31'd0, m_fall});
    check("event_valid", {31'd0, event_valid}, {31'd0, m_valid});
    check("event_type",  {31'd0, event_type},  {31'd0, m_type});
    check("overrun",     {31'd0, overrun},     {31'd0, m_ovr});
    check("event_count", 32'(event_count),     32'(m_cnt));
    check("count_w3",    32'(event_count3),    32'(m_cnt3));
    check("valid_w3",    {31'd0, event_valid3}, {31'd0, m_valid});
    check("level_w3",    {31'd0, level_filt3},  {31'd0, m_level});
  endtask

  task automatic step(input logic d, input logic r, input logic c, input logic rn);
    data_in     = d;
    event_ready = r;
    clear       = c;
    reset_n     = rn;
    @(posedge clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic run(input logic d, input logic r, input logic c, input logic rn, input int n);
    for (int i = 0; i < n; i++) step(d, r, c, rn);
  endtask

  initial begin
    int   hold;
    logic d;
    data_in = 0; event_ready = 0; clear = 0; reset_n = 0;
    m_level = 0; m_rise = 0; m_fall = 0; m_valid = 0; m_type = 0; m_ovr = 0;
    m_run = 0; m_cnt = 0; m_cnt3 = 0;
    @(negedge clock);

    run(0, 0, 0, 0, 2);                 // reset state
    run(1, 0, 0, 1, 3);                 // too-short high pulse
    run(0, 0, 0, 1, 3);
    check("short_pulse_cnt", 32'(event_count), 32'd0);
    run(1, 0, 0, 1, 4);                 // accepted rise
    check("rise_after_4", {31'd0, rise_pulse}, 32'd1);
    run(1, 1, 0, 1, 1);                 // handshake
    check("valid_after_hs", {31'd0, event_valid}, 32'd0);

    run(0, 0, 0, 0, 1);                 // overrun: rise then fall with ready low
    run(1, 0, 0, 1, 4);
    run(0, 0, 0, 1, 4);
    check("ovr_type", {31'd0, event_type}, 32'd1);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    run(0, 0, 1, 1, 1);                 // clear keeps pending event
    check("clr_valid", {31'd0, event_valid}, 32'd1);
    check("clr_cnt", 32'(event_count), 32'd0);

    for (int e = 0; e < 10; e++) run(e[0] ? 1'b0 : 1'b1, 1, 0, 1, S);
    check("sat_w3", 32'(event_count3), 32'd7);

    run(0, 1, 0, 1, 2);                 // reset mid-qualification with pending event
    run(1, 0, 0, 1, 6);
    run(0, 0, 0, 1, 2);
    run(1, 1, 0, 0, 1);
    check("rst_valid", {31'd0, event_valid}, 32'd0);
    run(1, 0, 0, 1, 4);
    check("rise_after_rst", {31'd0, level_filt}, 32'd1);

    run(0, 0, 0, 1, 3);                 // fall accepted in a handshake cycle
    run(0, 1, 0, 1, 1);
    check("hs_load_type", {31'd0, event_type}, 32'd0);
    check("hs_load_ovr",  {31'd0, overrun}, 32'd0);

    hold = 0;
    d    = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        d    = 1'($urandom % 2);
        hold = $urandom_range(1, 7);
      end
      hold--;
      step(d, ($urandom % 4) != 0, ($urandom % 60) == 0, ($urandom % 400) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_event_filter
`default_nettype wire

// File: doc/sync_event_filter.md
SYNC_EVENT_FILTER -- requirements
Module: sync_event_filter

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4 (range 2..255), the number of consecutive equal samples needed to accept a level change.
REQ-002 The module SHALL have parameter CNT_W, default 16, the width of the event counter.
REQ-003 Port: clock  input  1  the single clock; every register updates on its rising edge.
REQ-004 Port: reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clock.
REQ-005 Port: data_in  input  1  level already synchronised into the clock domain by the upstream two-flop synchroniser.
REQ-006 Port: clear  input  1  synchronous clear of event_count and overrun.
REQ-007 Port: level_filt  output  1  debounced level.
REQ-008 Port: rise_pulse, fall_pulse  output  1 each  one-cycle strobes on accepted edges.
REQ-009 Port: event_valid  output  1, event_type  output  1 (1=rise, 0=fall), event_ready  input  1  valid/ready event handshake.
REQ-010 Port: event_count  output  CNT_W  saturating count of accepted edges; overrun  output  1  sticky lost-event flag.

Function
REQ-011 The FSM SHALL have the states IDLE_LOW, QUAL_HIGH, IDLE_HIGH and QUAL_LOW, with an 8-bit stability counter stab_cnt.
REQ-012 In IDLE_LOW with data_in=1, the FSM SHALL go to QUAL_HIGH with stab_cnt=1; in IDLE_HIGH with data_in=0, it SHALL go to QUAL_LOW with stab_cnt=1.
REQ-013 In QUAL_HIGH or QUAL_LOW, a sample equal to the old level SHALL abort back to the matching IDLE state with stab_cnt=0, and produce no pulse, event or count.
REQ-014 In QUAL_HIGH or QUAL_LOW, a sample equal to the new level SHALL increment stab_cnt; when the incremented value equals STABLE_CYCLES, the FSM SHALL enter the new IDLE state.
REQ-015 The FSM transition on acceptance SHALL occur in the same cycle as the following register updates: level_filt toggles, the matching pulse is 1 for exactly one cycle, and the event is offered.
REQ-016 Latency: when data_in is 1 on S=STABLE_CYCLES consecutive edges t0..t0+S-1, level_filt and rise_pulse SHALL be 1 immediately after edge t0+S-1; any pulse shorter than S samples SHALL be rejected.
REQ-017 Handshake: event_valid and event_type SHALL hold stable until a cycle with event_valid=1 and event_ready=1, after which event_valid SHALL clear unless a new event loads in that same cycle.
REQ-018 A new event arriving while event_valid=1 and event_ready=0 SHALL be dropped, keep the pending event, and set overrun.
REQ-019 A new event arriving in the same cycle as a handshake SHALL load with event_valid remaining 1 and no overrun.
REQ-020 event_count SHALL increment by 1 on every accepted edge (including dropped events) and saturate at 2^CNT_W-1 without wrapping.
REQ-021 clear=1 SHALL set event_count=0 and overrun=0 on the next edge; it has priority over a simultaneous edge (that edge is not counted), and it does not affect the FSM, level_filt or the handshake.

Reset
REQ-022 While reset_n=0 at an edge, the block SHALL set state=IDLE_LOW, stab_cnt=0, level_filt=0, rise_pulse=0, fall_pulse=0, event_valid=0, event_type=0, event_count=0 and overrun=0.
REQ-023 Reset mid-qualification or with a pending event SHALL discard both, and the handshake SHALL not complete.
REQ-024 After reset, a data_in held at 1 SHALL be qualified as a normal rising edge.

Structure
REQ-025 A shared package/header sync_filter_pkg SHALL hold the 2-bit state encodings (IDLE_LOW=0, QUAL_HIGH=1, IDLE_HIGH=2, QUAL_LOW=3) and the EVT_RISE/EVT_FALL constants.
REQ-026 The saturating counter SHALL be one sub-module, sat_counter (parameter W; inputs inc and clr; output count), with clr having priority.
REQ-027 The block SHALL have no latches and no combinational path from data_in to any output.

Verification
REQ-028 Scenario: STABLE_CYCLES=4, data_in high for 3 cycles then low -> no pulse, level_filt stays 0, event_count=0.
REQ-029 Scenario: data_in high for 4 cycles -> rise_pulse exactly one cycle after the 4th high edge; event_valid=1, event_type=1, event_count=1; with event_ready=1 one cycle later, event_valid=0.
REQ-030 Scenario: event_ready held 0, then rise followed by fall -> event_type stays 1, overrun=1, event_count=2; after clear=1 for one cycle, count=0 and overrun=0 while event_valid remains 1.
REQ-031 Scenario: CNT_W=3, eight accepted edges -> event_count reaches 7 and stays at 7.
REQ-032 Scenario: reset_n=0 pulsed during QUAL_HIGH with an event pending -> all outputs 0 on the next edge; with data_in still 1, a rise is accepted 4 cycles after reset release.
REQ-033 Scenario: event_ready=1 in the same cycle a new fall event is accepted -> event_valid stays 1, event_type=0, overrun=0.
